sample_player: RTL and testbench

- Downstream stage of the flash-to-sample-memory loader.
- Once the loader has filled the 256 x 16 on-chip sample memory, this block reads the samples back in address order.
- Each sample is scaled by a volume shift, widened to the codec width, and handed to the audio codec output FIFO (valid/ready) at a fixed sample rate derived from the 50 MHz clock.
- Supports one-shot and looped playback, and flags pacing underruns.

---
 rtl/sample_player_pkg.sv | 17 +
 rtl/sample_rate_divider.sv | 42 ++++
 rtl/sample_player.sv | 168 ++++++++++++++++
 tb/tb_sample_player.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_player_pkg.sv
// Shared types and constants for the sample playback path.
package sample_player_pkg;

   localparam int SAMPLE_W            = 16;
   localparam int DEFAULT_DIV         = 1042;
   localparam int DEFAULT_NUM_SAMPLES = 256;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT_Q = 3'd2,
      ST_HOLD   = 3'd3,
      ST_PUSH   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/sample_rate_divider.sv
// Free-running sample-rate tick generator: one tick every DIV enabled cycles.
// The count is held at zero whenever the divider is disabled, so the first
// tick after enabling lands exactly DIV cycles later.
module sample_rate_divider
   import sample_player_pkg::*;
#(
   parameter int DIV = DEFAULT_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = en && (cnt_q == CNT_LAST);

   // Next count: clear when idle or on the tick, otherwise advance.
   always_comb begin
      cnt_d = cnt_q;
      if (!en || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sample_player.sv
// Reads the sample memory in address order, applies the volume shift and
// widens each sample to the codec width, then releases one sample per
// sample-rate tick to the codec FIFO over a valid/ready handshake.
module sample_player
   import sample_player_pkg::*;
#(
   parameter int NUM_SAMPLES = DEFAULT_NUM_SAMPLES,
   parameter int ADDR_W      = 8,
   parameter int RD_LAT      = 1,
   parameter int DIV         = DEFAULT_DIV,
   parameter int OUT_W       = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              loop_en,
   input  logic [3:0]        vol_shift,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_q,
   output logic              aud_valid,
   input  logic              aud_ready,
   output logic [OUT_W-1:0]  aud_left,
   output logic [OUT_W-1:0]  aud_right,
   output logic              busy,
   output logic              done,
   output logic              underrun
);

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_SAMPLES - 1);
   localparam logic [1:0]        LAST_WAIT = 2'(RD_LAT - 1);

   state_t            state_q,  state_d;
   logic [ADDR_W-1:0] idx_q,    idx_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [1:0]        wait_q,   wait_d;
   logic [OUT_W-1:0]  sample_q, sample_d;
   logic [OUT_W-1:0]  left_q,   left_d;
   logic              pend_q,   pend_d;
   logic              und_q,    und_d;

   logic              tick;
   logic              consume;
   logic signed [OUT_W-1:0] sample_ext;
   logic signed [OUT_W-1:0] sample_scaled;

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign aud_valid = (state_q == ST_PUSH);
   assign mem_addr  = addr_q;
   assign aud_left  = left_q;
   assign aud_right = left_q;
   assign underrun  = und_q;

   sample_rate_divider #(
      .DIV (DIV)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (busy),
      .tick  (tick)
   );

   // Sign-extend, move the 16-bit sample to the top of the codec word,
   // then attenuate with an arithmetic shift (no clamping: -1 is the floor).
   always_comb begin
      sample_ext    = OUT_W'(signed'(mem_q));
      sample_scaled = (sample_ext <<< (OUT_W - SAMPLE_W)) >>> vol_shift;
   end

   // Playback sequencing plus tick bookkeeping (pending tick and underrun).
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      wait_d   = wait_q;
      sample_d = sample_q;
      left_d   = left_q;
      pend_d   = pend_q;
      und_d    = und_q;

      // A tick arriving while HOLD consumes the previous one stays pending;
      // a tick landing on an unconsumed one is dropped and flagged.
      consume = (state_q == ST_HOLD) && pend_q;
      if (consume) begin
         pend_d = tick;
      end else if (tick) begin
         if (pend_q) begin
            und_d = 1'b1;
         end
         pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               idx_d   = '0;
               addr_d  = '0;
               pend_d  = 1'b0;
               und_d   = 1'b0;
            end
         end
         ST_FETCH: begin
            wait_d  = '0;
            state_d = ST_WAIT_Q;
         end
         ST_WAIT_Q: begin
            if (wait_q == LAST_WAIT) begin
               sample_d = sample_scaled;
               state_d  = ST_HOLD;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (pend_q) begin
               left_d  = sample_q;
               state_d = ST_PUSH;
            end
         end
         ST_PUSH: begin
            if (aud_ready) begin
               if (idx_q < LAST_IDX) begin
                  idx_d   = idx_q + 1'b1;
                  addr_d  = idx_q + 1'b1;
                  state_d = ST_FETCH;
               end else if (loop_en) begin
                  idx_d   = '0;
                  addr_d  = '0;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any playback or pending handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         wait_q   <= '0;
         sample_q <= '0;
         left_q   <= '0;
         pend_q   <= 1'b0;
         und_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         wait_q   <= wait_d;
         sample_q <= sample_d;
         left_q   <= left_d;
         pend_q   <= pend_d;
         und_q    <= und_d;
      end
   end

endmodule

// File: tb/tb_sample_player.sv
// Bench for sample_player: event-level playback model compared every cycle,
// plus literal expectations for selected transfers and flags.
module tb_sample_player;

   localparam int NS  = 40;
   localparam int DV  = 8;
   localparam int RDL = 2;
   localparam int OW  = 24;
   localparam int AW  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          loop_en = 1'b0;
   logic [3:0]    vol_shift = 4'd0;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_q;
   logic          aud_valid;
   logic          aud_ready = 1'b1;
   logic [OW-1:0] aud_left;
   logic [OW-1:0] aud_right;
   logic          busy;
   logic          done;
   logic          underrun;

   int n_checks = 0;
   int n_err    = 0;
   int n_done   = 0;
   bit chk_en   = 1'b0;
   logic [OW-1:0] obs[$];

   logic [15:0] mem [0:NS-1];
   logic [15:0] mem_p1;

   always #5 clk = ~clk;

   sample_player #(
      .NUM_SAMPLES (NS),
      .ADDR_W      (AW),
      .RD_LAT      (RDL),
      .DIV         (DV),
      .OUT_W       (OW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .loop_en   (loop_en),
      .vol_shift (vol_shift),
      .mem_addr  (mem_addr),
      .mem_q     (mem_q),
      .aud_valid (aud_valid),
      .aud_ready (aud_ready),
      .aud_left  (aud_left),
      .aud_right (aud_right),
      .busy      (busy),
      .done      (done),
      .underrun  (underrun)
   );

   // Sample memory with a two-cycle registered read.
   always @(posedge clk) begin
      mem_p1 <= mem[mem_addr];
      mem_q  <= mem_p1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Sample scaling as plain integer arithmetic: x*256, floor-divided by 2^v.
   function automatic logic [OW-1:0] scale(input logic [15:0] s, input logic [3:0] v);
      int x;
      x = int'($signed(s)) * 256;
      x = x >>> v;
      return x[OW-1:0];
   endfunction

   // ---------------- behavioural model ----------------
   // Time is counted in clock edges since start was accepted. Ticks fall on
   // multiples of DV; a fetched sample can first be shown RDL+2 edges after
   // its fetch began, and is shown on the first such edge that follows an
   // unconsumed tick.
   int            m_t = 0, m_idx = 0, m_avail = 0;
   bit            m_act = 0, m_done_ph = 0, m_pend = 0, m_valid = 0, m_und = 0;
   logic [OW-1:0] m_val = '0;
   logic [AW-1:0] m_addr = '0;
   logic [3:0]    m_vol = '0;

   always @(posedge clk) begin
      bit tk, cons;
      tk   = 1'b0;
      cons = 1'b0;
      if (!rst_n) begin
         m_act = 0; m_done_ph = 0; m_pend = 0; m_valid = 0; m_und = 0;
         m_val = '0; m_addr = '0; m_idx = 0; m_t = 0;
      end else if (m_act) begin
         m_t++;
         tk = (m_t % DV) == 0;
         if (m_done_ph) begin
            m_done_ph = 0;
            m_act     = 0;
         end else begin
            if (m_t == m_avail - 1) m_vol = vol_shift;
            cons = !m_valid && m_pend && (m_t >= m_avail);
            if (m_valid && aud_ready) begin
               m_valid = 0;
               if (m_idx < NS - 1) begin
                  m_idx++;
               end else if (loop_en) begin
                  m_idx = 0;
               end else begin
                  m_done_ph = 1;
               end
               if (!m_done_ph) begin
                  m_addr  = AW'(m_idx);
                  m_avail = m_t + RDL + 2;
               end
            end else if (cons) begin
               m_valid = 1;
               m_val   = scale(mem[m_idx], m_vol);
            end
         end
         if (cons) m_pend = tk;
         else if (tk) begin
            if (m_pend) m_und = 1;
            m_pend = 1;
         end
      end else if (start) begin
         m_act = 1; m_t = 0; m_idx = 0; m_addr = '0; m_avail = RDL + 2;
         m_pend = 0; m_und = 0; m_valid = 0;
      end
   end

   // Per-cycle comparison against the model and transfer logging.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",      busy,      m_act);
         chk("done",      done,      m_done_ph);
         chk("aud_valid", aud_valid, m_valid);
         chk("aud_left",  aud_left,  m_val);
         chk("aud_right", aud_right, m_val);
         chk("mem_addr",  mem_addr,  m_addr);
         chk("underrun",  underrun,  m_und);
      end
      if (aud_valid === 1'b1 && aud_ready === 1'b1) begin
         obs.push_back(aud_left);
         $display("xfer n=%0d addr_next=%0d data=%06h", obs.size() - 1, mem_addr, aud_left);
      end
      if (done === 1'b1) n_done++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_valid(input int bound, input string nm, output int lat);
      lat = 0;
      while (aud_valid !== 1'b1 && lat < bound) begin
         step(1);
         lat++;
      end
      chk(nm, aud_valid, 1);
   endtask

   task automatic wait_done(input int bound, input string nm);
      int k;
      k = 0;
      while (done !== 1'b1 && k < bound) begin
         step(1);
         k++;
      end
      chk(nm, done, 1);
      step(2);
   endtask

   task automatic wait_xfers(input int n, input int bound, input string nm);
      int k;
      k = 0;
      while (obs.size() < n && k < bound) begin
         step(1);
         k++;
      end
      chk(nm, obs.size() >= n, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int d0;
      for (int i = 0; i < NS; i++) mem[i] = 16'((i * 1327) ^ 16'hA5A5);
      mem[0] = 16'h0001;
      mem[1] = 16'h7FFF;
      mem[2] = 16'h8000;
      mem[3] = 16'hFFFF;
      mem[4] = 16'h4000;

      // Reset
      step(2);
      chk_en = 1'b1;
      step(1);
      rst_n = 1'b1;
      chk("rst_busy",  busy,      0);
      chk("rst_valid", aud_valid, 0);
      chk("rst_addr",  mem_addr,  0);
      chk("rst_left",  aud_left,  0);
      step(2);

      // One-shot, vol 0, with ignored start pulses while busy
      obs.delete();
      d0 = n_done;
      pulse_start();
      wait_valid(50, "first_valid_timeout", lat);
      chk("first_valid_latency", lat, DV + 1);
      step(30);
      pulse_start();
      step(77);
      pulse_start();
      wait_done(600, "oneshot_done_timeout");
      chk("oneshot_s0", obs[0], 24'h000100);
      chk("oneshot_s1", obs[1], 24'h7FFF00);
      chk("oneshot_s2", obs[2], 24'h800000);
      chk("oneshot_s3", obs[3], 24'hFFFF00);
      chk("oneshot_count", obs.size(), NS);
      chk("oneshot_done_pulses", n_done - d0, 1);
      chk("oneshot_busy_low", busy, 0);

      // Volume shift 4
      obs.delete();
      vol_shift = 4'd4;
      pulse_start();
      wait_done(600, "vol4_done_timeout");
      chk("vol4_s0", obs[0], 24'h000010);
      chk("vol4_s2", obs[2], 24'hF80000);

      // Volume shift 15
      obs.delete();
      vol_shift = 4'd15;
      pulse_start();
      wait_done(600, "vol15_done_timeout");
      chk("vol15_s2", obs[2], 24'hFFFF00);
      chk("vol15_s3", obs[3], 24'hFFFFFF);
      chk("vol15_s4", obs[4], 24'h000080);

      // Backpressure: ready low for 20 cycles from the first valid
      obs.delete();
      vol_shift = 4'd0;
      pulse_start();
      wait_valid(50, "bp_valid_timeout", lat);
      aud_ready = 1'b0;
      step(20);
      chk("bp_underrun_set", underrun, 1);
      chk("bp_valid_held", aud_valid, 1);
      chk("bp_data_held", aud_left, 24'h000100);
      aud_ready = 1'b1;
      wait_done(800, "bp_done_timeout");
      chk("bp_order_s1", obs[1], 24'h7FFF00);
      chk("bp_count", obs.size(), NS);
      chk("bp_underrun_sticky", underrun, 1);
      obs.delete();
      pulse_start();
      chk("bp_underrun_cleared", underrun, 0);
      wait_done(600, "bp2_done_timeout");

      // Loop: wrap once, then drop loop_en early in the second pass
      obs.delete();
      d0 = n_done;
      loop_en = 1'b1;
      pulse_start();
      wait_xfers(NS + 4, 1000, "loop_xfer_timeout");
      chk("loop_no_done", n_done - d0, 0);
      loop_en = 1'b0;
      wait_done(800, "loop_done_timeout");
      chk("loop_wrap_s40", obs[NS], 24'h000100);
      chk("loop_count", obs.size(), 2 * NS);
      chk("loop_done_pulses", n_done - d0, 1);

      // Reset while presenting index 37
      obs.delete();
      pulse_start();
      wait_xfers(37, 800, "rstmid_xfer_timeout");
      wait_valid(50, "rstmid_valid_timeout", lat);
      rst_n = 1'b0;
      step(1);
      chk("rstmid_valid", aud_valid, 0);
      chk("rstmid_busy",  busy,      0);
      chk("rstmid_addr",  mem_addr,  0);
      chk("rstmid_left",  aud_left,  0);
      chk("rstmid_done",  done,      0);
      rst_n = 1'b1;
      step(2);
      obs.delete();
      pulse_start();
      wait_done(600, "replay_done_timeout");
      chk("replay_s0", obs[0], 24'h000100);
      chk("replay_count", obs.size(), NS);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
